// File: rtl/mem_access_stage.sv
// Memory-access stage: ALU pass-through, req/ack data-memory transactions with stall.
// Optional ack timeout with sticky error enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_wb_dir,
    input  logic        i_we,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_stall,
    output logic        o_WE_MEM_WB,
    output logic [31:0] o_WB_Data,
    output logic [31:0] o_WB_Dir,
    output logic        o_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic        mem_op;
    logic        expire;
    logic        is_load_q;
    logic        we_q;
    logic        tout_q;
    logic [31:0] rdata_q;
    logic [31:0] dir_q;

    assign mem_op = i_valid & (i_mem_rd | i_mem_wr);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt + 8'd1;
    // Ack on the expiry edge wins, so expiry requires ack low.
    assign expire = (state == REQ) & ~i_mem_ack
                  & (cnt_inc == 8'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 8'd0;
            o_err <= 1'b0;
        end else begin
            if (state == IDLE && mem_op) begin
                cnt <= 8'd0;
            end else if (state == REQ && !i_mem_ack) begin
                cnt <= cnt_inc;
            end
            if (expire) begin
                o_err <= 1'b1;
            end
        end
    end
`else
    assign expire = 1'b0;
    assign o_err  = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        o_stall     = 1'b0;
        o_WE_MEM_WB = 1'b0;
        o_WB_Data   = i_alu_result;
        o_WB_Dir    = i_wb_dir;
        unique case (state)
            IDLE: begin
                if (mem_op) begin
                    o_stall   = 1'b1;
                    state_nxt = REQ;
                end else begin
                    o_WE_MEM_WB = i_valid & i_we;
                end
            end
            REQ: begin
                o_stall = 1'b1;
                if (i_mem_ack || expire) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_WB_Dir    = dir_q;
                o_WE_MEM_WB = is_load_q & we_q & ~tout_q;
                if (tout_q) begin
                    o_WB_Data = 32'hDEADBEEF;
                end else if (is_load_q) begin
                    o_WB_Data = rdata_q;
                end else begin
                    o_WB_Data = 32'd0;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 32'd0;
            rdata_q     <= 32'd0;
            dir_q       <= 32'd0;
            is_load_q   <= 1'b0;
            we_q        <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (mem_op) begin
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_mem_wr;
                        o_mem_addr  <= i_addr;
                        o_mem_wdata <= i_wdata;
                        dir_q       <= i_wb_dir;
                        // Store wins when both rd and wr are set.
                        is_load_q   <= ~i_mem_wr;
                        we_q        <= i_we;
                        tout_q      <= 1'b0;
                    end
                end
                REQ: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        if (is_load_q) begin
                            rdata_q <= i_mem_rdata;
                        end
                    end else if (expire) begin
                        o_mem_req <= 1'b0;
                        tout_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops, monitor checks WB outputs.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

    localparam int unsigned MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_mem_rd = 1'b0;
    logic        i_mem_wr = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] i_alu_result = '0;
    logic [31:0] i_wb_dir = '0;
    logic        i_we = 1'b0;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_stall;
    logic        o_WE_MEM_WB;
    logic [31:0] o_WB_Data;
    logic [31:0] o_WB_Dir;
    logic        o_err;

    mem_access_stage #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid),
        .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .i_alu_result(i_alu_result), .i_wb_dir(i_wb_dir),
        .i_we(i_we), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_stall(o_stall),
        .o_WE_MEM_WB(o_WE_MEM_WB), .o_WB_Data(o_WB_Data),
        .o_WB_Dir(o_WB_Dir), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
        logic [31:0] dir;
    } wb_t;

    wb_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  ack_e1, req_e1, ack_e2, req_e2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a WB result is presented whenever a valid instruction is not stalled.
    always @(negedge clk) begin
        if (!rst && i_valid && !o_stall) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_we", {31'd0, o_WE_MEM_WB}, {31'd0, e.we});
                chk("wb_data", o_WB_Data, e.data);
                chk("wb_dir", o_WB_Dir, e.dir);
            end
        end
    end

    task automatic nonmem(input logic [31:0] alu, input logic [31:0] dir,
                          input logic we, input logic exp_we);
        i_valid = 1'b1; i_mem_rd = 1'b0; i_mem_wr = 1'b0;
        i_alu_result = alu; i_wb_dir = dir; i_we = we;
        exp_q.push_back('{we: exp_we, data: alu, dir: dir});
        @(negedge clk);
        chk("nm_stall", {31'd0, o_stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the DONE cycle.
    task automatic mem_op(input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] dir, input logic we,
                          input int ack_at, input logic [31:0] rdata,
                          input wb_t exp, input int exp_stalls,
                          input int exp_reqs,
                          output int ack_edge, output int req_edge);
        int stalls, reqs;
        bit done;
        stalls = 0; reqs = 0; done = 0;
        ack_edge = -1; req_edge = -1;
        i_valid = 1'b1; i_mem_rd = rd; i_mem_wr = wr;
        i_addr = addr; i_wdata = wdata; i_wb_dir = dir; i_we = we;
        i_alu_result = 32'h0BAD0BAD;
        exp_q.push_back(exp);
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (o_stall) stalls++;
            else done = 1;
            if (!done && k == 0)
                chk("op_we_idle", {31'd0, o_WE_MEM_WB}, 32'd0);
            if (o_mem_req) begin
                reqs++;
                if (req_edge < 0) req_edge = cyc;
                chk("req_addr", o_mem_addr, addr);
                chk("req_wdata", o_mem_wdata, wdata);
                chk("req_we", {31'd0, o_mem_we}, {31'd0, wr});
                // Source values change; registered copies must not.
                i_addr = ~addr; i_wdata = ~wdata; i_wb_dir = ~dir;
                i_alu_result = 32'h55AA55AA;
                if (reqs == ack_at) begin
                    i_mem_ack = 1'b1; i_mem_rdata = rdata;
                    ack_edge = cyc + 1;
                end
            end
            if (done) chk("done_req_low", {31'd0, o_mem_req}, 32'd0);
            @(posedge clk); #1;
            i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
        end
        if (!done) chk("op_timeout", 32'd1, 32'd0);
        chk("stall_cycles", stalls, exp_stalls);
        chk("req_cycles", reqs, exp_reqs);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Reset mid-REQ
        i_valid = 1'b1; i_mem_rd = 1'b1; i_addr = 32'h40;
        @(posedge clk); #1;
        chk("mid_req_up", {31'd0, o_mem_req}, 32'd1);
        chk("mid_req_addr", o_mem_addr, 32'h40);
        #2 rst = 1'b1;
        #1 chk("mid_rst_req", {31'd0, o_mem_req}, 32'd0);
        i_valid = 1'b0;
        #1 chk("mid_rst_stall", {31'd0, o_stall}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h11111111;
        @(negedge clk);
        chk("late_ack_req", {31'd0, o_mem_req}, 32'd0);
        chk("late_ack_stall", {31'd0, o_stall}, 32'd0);
        chk("late_ack_we", {31'd0, o_WE_MEM_WB}, 32'd0);
        @(posedge clk); #1 i_mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_we2", {31'd0, o_WE_MEM_WB}, 32'd0);
        @(posedge clk); #1;

        // Non-memory ops
        nonmem(32'h1234, 32'd5, 1'b1, 1'b1);
        nonmem(32'hFFFF0000, 32'd31, 1'b0, 1'b0);
        i_valid = 1'b0; i_we = 1'b1;
        #1 chk("inv_we", {31'd0, o_WE_MEM_WB}, 32'd0);
        @(posedge clk); #1;

        // Load, ack on 3rd REQ cycle
        mem_op(1'b1, 1'b0, 32'h100, 32'h0, 32'd7, 1'b1, 3, 32'hCAFEF00D,
               '{we: 1'b1, data: 32'hCAFEF00D, dir: 32'd7}, 4, 3,
               ack_e1, req_e1);
        i_valid = 1'b0;
        @(negedge clk);
        chk("ld_we_once", {31'd0, o_WE_MEM_WB}, 32'd0);
        @(posedge clk); #1;

        // Store with rd=wr=1, immediate ack
        mem_op(1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 32'd9, 1'b1, 1,
               32'h77777777, '{we: 1'b0, data: 32'h0, dir: 32'd9}, 2, 1,
               ack_e1, req_e1);
        i_valid = 1'b0;
        @(posedge clk); #1;

        // Load with i_we=0: result visible, no register write
        mem_op(1'b1, 1'b0, 32'h300, 32'h0, 32'd3, 1'b0, 2, 32'h12345678,
               '{we: 1'b0, data: 32'h12345678, dir: 32'd3}, 3, 2,
               ack_e1, req_e1);

        // Back-to-back loads
        mem_op(1'b1, 1'b0, 32'h10, 32'h0, 32'd1, 1'b1, 1, 32'hAAAA0001,
               '{we: 1'b1, data: 32'hAAAA0001, dir: 32'd1}, 2, 1,
               ack_e1, req_e1);
        mem_op(1'b1, 1'b0, 32'h14, 32'h0, 32'd2, 1'b1, 2, 32'hBBBB0002,
               '{we: 1'b1, data: 32'hBBBB0002, dir: 32'd2}, 3, 2,
               ack_e2, req_e2);
        chk("b2b_gap", req_e2 - ack_e1, 32'd2);
        i_valid = 1'b0;
        @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
        mem_op(1'b1, 1'b0, 32'h500, 32'h0, 32'd4, 1'b1, 0, 32'h0,
               '{we: 1'b0, data: 32'hDEADBEEF, dir: 32'd4}, 5, 4,
               ack_e1, req_e1);
        i_valid = 1'b0;
        chk("to_err_set", {31'd0, o_err}, 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("to_err_held", {31'd0, o_err}, 32'd1);
        nonmem(32'h42, 32'd6, 1'b1, 1'b1);
        chk("to_err_held2", {31'd0, o_err}, 32'd1);
        i_valid = 1'b0;
        rst = 1'b1;
        #1 chk("to_err_clr", {31'd0, o_err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
`else
        chk("err_tied", {31'd0, o_err}, 32'd0);
`endif

        @(posedge clk); #1;
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the filter-processor pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Passes ALU results straight through for non-memory instructions.
- For loads and stores, runs a req/ack transaction with data memory and stalls the pipeline until it completes.
- Drives the MEM/WB register inputs (WB data, WB dir, write-enable) and its active-high EN hold input.

Parameters:
MAX_WAIT, 255, ack-wait cycles before abort (used only with MEM_TIMEOUT_EN); legal 1..255, 8-bit counter.

Ports:
clk  input  1  pipeline clock; all state changes on posedge
rst  input  1  reset, asynchronous, active-high
i_valid  input  1  instruction in MEM stage is valid
i_mem_rd  input  1  instruction is a load
i_mem_wr  input  1  instruction is a store
i_addr  input  32  memory address
i_wdata  input  32  store data
i_alu_result  input  32  writeback value for non-memory instructions
i_wb_dir  input  32  destination register address
i_we  input  1  instruction writes the register file
i_mem_ack  input  1  memory completion strobe
i_mem_rdata  input  32  load data, valid with i_mem_ack
o_mem_req  output  1  memory request (registered)
o_mem_we  output  1  1 = write, 0 = read (registered)
o_mem_addr  output  32  registered address
o_mem_wdata  output  32  registered store data
o_stall  output  1  1 = hold; wired to EN of EX/MEM and MEM/WB and upstream registers
o_WE_MEM_WB  output  1  register-file write enable toward MEM/WB
o_WB_Data  output  32  writeback data toward MEM/WB
o_WB_Dir  output  32  writeback destination toward MEM/WB
o_err  output  1  sticky timeout error

Behaviour:
- Reset (async, any state): state=IDLE; o_mem_req=0; o_mem_we=0; o_mem_addr=0; o_mem_wdata=0; captured rdata=0; wait counter=0; o_err=0.
  - IDLE combinational outputs follow from the rules below, so stall=0 and WE=0 when i_valid=0.
  - Reset mid-transaction drops o_mem_req immediately. A later ack is ignored.
- A memory op is i_valid & (i_mem_rd | i_mem_wr). If both are set, the store wins and no register write occurs.
- FSM states: IDLE, REQ, DONE.
- IDLE, no memory op:
  - o_WB_Data=i_alu_result, o_WB_Dir=i_wb_dir, o_WE_MEM_WB=i_valid & i_we (combinational).
  - o_stall=0; zero added latency.
- IDLE, memory op:
  - o_stall=1 and o_WE_MEM_WB=0 (combinational).
  - On the next edge: register addr, wdata, we=i_mem_wr, dir, and load flag; set o_mem_req=1; go to REQ.
- REQ:
  - o_stall=1, o_WE_MEM_WB=0.
  - o_mem_req and the address/data/we outputs stay stable until i_mem_ack is sampled high.
  - On an edge with ack=1: capture i_mem_rdata if the op is a load; o_mem_req=0; go to DONE.
- DONE (exactly one cycle):
  - o_stall=0.
  - o_WB_Data = captured rdata for a load; for a store it is 0.
  - o_WB_Dir = latched dir.
  - o_WE_MEM_WB = 1 for a load with latched i_we, 0 for a store.
  - Next edge: go to IDLE unconditionally. The held instruction is not re-issued because the pipeline advances on this edge.
- i_mem_ack outside REQ is ignored.
- Latency: with ack on the first REQ cycle, a memory op occupies the stage for 3 cycles (IDLE, REQ, DONE); each extra ack-wait cycle adds one.
- Back-to-back memory ops: DONE → IDLE → new request. One idle bubble on the memory bus is required.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - Counter clears on entry to REQ and increments on each REQ cycle without ack.
  - When the counter equals MAX_WAIT and ack=0: drop o_mem_req, go to DONE with o_WB_Data=32'hDEADBEEF and o_WE_MEM_WB=0, and set o_err=1 (sticky, cleared only by rst).
  - Ack on the same edge as expiry takes priority: normal completion, no error.
- Undefined:
  - REQ waits indefinitely; o_err is tied to 0; the counter is not synthesized.

Test Plan:
- rst pulse mid-REQ (addr 0x40) → o_mem_req falls asynchronously, state IDLE, o_stall=0 with i_valid=0; a late ack is ignored.
- Non-memory op (alu=0x1234, dir=5, we=1) → same cycle: o_WB_Data=0x1234, o_WB_Dir=5, o_WE_MEM_WB=1, o_stall=0.
- Load addr 0x100, ack on the 3rd REQ cycle with rdata 0xCAFEF00D → o_stall high for 4 cycles; then DONE: o_WB_Data=0xCAFEF00D, o_WE_MEM_WB=1 for one cycle.
- Store addr 0x200 wdata 0xA5A5A5A5 with rd=wr=1, ack immediate → o_mem_we=1, addr and wdata stable while req; DONE with o_WE_MEM_WB=0.
- Back-to-back loads 0x10 then 0x14 → second o_mem_req rises exactly 2 cycles after the first ack edge; both results written in order.
- MEM_TIMEOUT_EN, MAX_WAIT=4, no ack → req drops after 4 REQ cycles, o_WB_Data=0xDEADBEEF, o_WE_MEM_WB=0, o_err=1 and held until rst.
